// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART program loader for the 128x32 instruction memory; LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module program_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          ADDR_W       = 7,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int WCNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_st_q;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             byte_valid, frame_err, len_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st_q   <= RX_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      case (rx_st_q)
        RX_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_sync_q && rx_prev_q) rx_st_q <= RX_START;
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            rx_st_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shreg_q   <= {rx_sync_q, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) rx_st_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == BIT_LAST) rx_st_q <= RX_IDLE;
          else                   cnt_q   <= cnt_q + CNT_W'(1);
        end
      endcase
    end
  end

  assign byte_valid = (rx_st_q == RX_STOP) && (cnt_q == BIT_LAST) &&  rx_sync_q;
  assign frame_err  = (rx_st_q == RX_STOP) && (cnt_q == BIT_LAST) && !rx_sync_q;
  assign len_ok     = (shreg_q != 8'd0) && ({24'd0, shreg_q} <= (32'd1 << ADDR_W));

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {WAIT_SYNC, GET_LEN, GET_DATA, GET_CSUM, RUN} state_t;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {WAIT_SYNC, GET_LEN, GET_DATA, RUN} state_t;
`endif

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WCNT_W-1:0]   len_q;
  logic [WCNT_W-1:0]   words_q;
  logic [1:0]          byte_idx_q;
  logic [31:0]         word_q;
  logic                mem_we_q, cpu_reset_q, err_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_SYNC;
      addr_q      <= '0;
      len_q       <= '0;
      words_q     <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (frame_err) begin
        err_q       <= 1'b1;
        cpu_reset_q <= 1'b1;
        state_q     <= WAIT_SYNC;
      end else begin
        case (state_q)
          WAIT_SYNC: if (byte_valid && shreg_q == SYNC_BYTE) state_q <= GET_LEN;
          GET_LEN: if (byte_valid) begin
            if (!len_ok) begin
              err_q   <= 1'b1;
              state_q <= WAIT_SYNC;
            end else begin
              len_q       <= WCNT_W'(shreg_q);
              words_q     <= '0;
              addr_q      <= '0;
              byte_idx_q  <= '0;
              cpu_reset_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
              csum_q      <= '0;
`endif
              state_q     <= GET_DATA;
            end
          end
          GET_DATA: begin
            // Address and word count advance on the write cycle itself.
            if (mem_we_q) begin
              addr_q  <= addr_q + ADDR_W'(1);
              words_q <= words_q + WCNT_W'(1);
              if (words_q + WCNT_W'(1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                state_q     <= GET_CSUM;
`else
                state_q     <= RUN;
                cpu_reset_q <= 1'b0;
`endif
              end
            end else if (byte_valid) begin
              word_q     <= {shreg_q, word_q[31:8]};
              byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
              csum_q     <= csum_q ^ shreg_q;
`endif
              if (byte_idx_q == 2'd3) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= addr_q;
                mem_wdata_q <= {shreg_q, word_q[31:8]};
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          GET_CSUM: if (byte_valid) begin
            if (shreg_q == csum_q) begin
              state_q     <= RUN;
              cpu_reset_q <= 1'b0;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_SYNC;
            end
          end
`endif
          RUN: if (byte_valid && shreg_q == SYNC_BYTE) begin
            cpu_reset_q <= 1'b1;
            state_q     <= GET_LEN;
          end
          default: state_q <= WAIT_SYNC;
        endcase
      end
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_reset_o = cpu_reset_q;
  assign err_o       = err_q;
  assign words_o     = words_q;
  assign busy_o      = (state_q != WAIT_SYNC) && (state_q != RUN);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed scoreboard bench for program_loader (CLKS_PER_BIT=4)
module tb_program_loader;
  localparam int CPB    = 4;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_i = 1'b1;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              cpu_reset_o, busy_o, err_o;
  logic [ADDR_W:0]   words_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  bit we_prev = 1'b0;
  bit cpu_prev = 1'b1;
  logic [38:0] exp_q[$];

  program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_i(rx_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .cpu_reset_o(cpu_reset_o), .busy_o(busy_o), .err_o(err_o), .words_o(words_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and release-timing monitor.
  always @(negedge clk) begin
    logic [38:0] e;
    cyc++;
    if (!reset && mem_we_o) begin
      check("we_width", 64'(we_prev), 64'd0);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 'x;
      check("write", 64'({mem_addr_o, mem_wdata_o}), 64'(e));
      last_we_cyc = cyc;
    end
`ifndef LOADER_CHECKSUM_EN
    if (!reset && cpu_prev && !cpu_reset_o)
      check("cpu_release_delay", 64'(cyc - last_we_cyc), 64'd1);
`endif
    we_prev  = mem_we_o;
    cpu_prev = cpu_reset_o;
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_bit = 1'b1);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] w;
    logic [7:0]  x;
    x = 8'h00;
    send_byte(8'hA5);
    send_byte(n[7:0]);
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : w1;
      exp_q.push_back({7'(k), w});
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8]);
        x = x ^ w[8*j +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x);
`endif
    repeat (5) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    64'(mem_we_o), 64'd0);
    check({tag, "_addr"},  64'(mem_addr_o), 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
    check({tag, "_cpu"},   64'(cpu_reset_o), 64'd1);
    check({tag, "_busy"},  64'(busy_o), 64'd0);
    check({tag, "_err"},   64'(err_o), 64'd0);
    check({tag, "_words"}, 64'(words_o), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    do_reset();
    check_reset_vals("rst");

    // Two-word frame
    send_frame(2, 32'h12345678, 32'hDEADBEEF);
    check("a_words", 64'(words_o), 64'd2);
    check("a_cpu", 64'(cpu_reset_o), 64'd0);
    check("a_busy", 64'(busy_o), 64'd0);
    check("a_err", 64'(err_o), 64'd0);
    check("a_pending", 64'(exp_q.size()), 64'd0);

    // Noise in RUN, then reload of a one-word frame
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    check("noise_cpu", 64'(cpu_reset_o), 64'd0);
    send_byte(8'hA5);
    repeat (2) @(negedge clk);
    check("reload_cpu", 64'(cpu_reset_o), 64'd1);
    check("reload_busy", 64'(busy_o), 64'd1);
    exp_q.push_back({7'd0, 32'h00000001});
    send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h01);
`endif
    repeat (5) @(negedge clk);
    check("noise_words", 64'(words_o), 64'd1);
    check("noise_err", 64'(err_o), 64'd0);
    check("noise_cpu_run", 64'(cpu_reset_o), 64'd0);
    check("noise_pending", 64'(exp_q.size()), 64'd0);

    // Length errors
    send_byte(8'hA5); send_byte(8'h00);
    repeat (3) @(negedge clk);
    check("len0_err", 64'(err_o), 64'd1);
    check("len0_cpu", 64'(cpu_reset_o), 64'd1);
    check("len0_busy", 64'(busy_o), 64'd0);
    do_reset();
    check("len_rst_err", 64'(err_o), 64'd0);
    send_byte(8'hA5); send_byte(8'h81);
    repeat (3) @(negedge clk);
    check("len81_err", 64'(err_o), 64'd1);
    check("len81_cpu", 64'(cpu_reset_o), 64'd1);
    check("len81_busy", 64'(busy_o), 64'd0);
    send_frame(1, 32'hCAFEF00D, 32'h0);
    check("len_recover_cpu", 64'(cpu_reset_o), 64'd0);
    check("len_recover_words", 64'(words_o), 64'd1);
    check("len_sticky_err", 64'(err_o), 64'd1);

    // Framing error on the 3rd data byte
    do_reset();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33, 1'b0);
    repeat (3) @(negedge clk);
    check("frm_err", 64'(err_o), 64'd1);
    check("frm_busy", 64'(busy_o), 64'd0);
    check("frm_cpu", 64'(cpu_reset_o), 64'd1);
    send_byte(8'h44);
    repeat (3) @(negedge clk);
    check("frm_words", 64'(words_o), 64'd0);
    check("frm_pending", 64'(exp_q.size()), 64'd0);

    // Reset after two data bytes
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    check("mid_busy", 64'(busy_o), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("midrst_rel");
    send_frame(1, 32'h13579BDF, 32'h0);
    check("mid_next_words", 64'(words_o), 64'd1);
    check("mid_next_cpu", 64'(cpu_reset_o), 64'd0);
    check("mid_next_err", 64'(err_o), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    send_frame(1, 32'h44332211, 32'h0);
    check("csum_ok_cpu", 64'(cpu_reset_o), 64'd0);
    check("csum_ok_err", 64'(err_o), 64'd0);
    exp_q.push_back({7'd0, 32'h44332211});
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h45);
    repeat (5) @(negedge clk);
    check("csum_bad_err", 64'(err_o), 64'd1);
    check("csum_bad_cpu", 64'(cpu_reset_o), 64'd1);
    check("csum_bad_busy", 64'(busy_o), 64'd0);
`endif
    check("final_pending", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
